// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic skew/deskew datapath: lane delay rule,
// width helper, state encoding and array defaults.
package systolic_pkg;

  localparam int SYS_LANES  = 32;
  localparam int SYS_DATA_W = 8;

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_DRAIN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Skew delays lane i by i beats; deskew mirrors it so the triangle closes.
  function automatic int lane_delay(input int lane, input int n, input bit reverse);
    return reverse ? (n - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/lane_delay_line.sv
// Enable-gated register chain of DEPTH beats; DEPTH 0 is a plain wire.
module lane_delay_line #(
  parameter int DEPTH      = 0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLOCK,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{CLOCK, reset, en};
      assign out = in;
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] taps_q [DEPTH];

      always_ff @(posedge CLOCK) begin
        if (reset) begin
          for (int t = 0; t < DEPTH; t++) taps_q[t] <= '0;
        end else if (en) begin
          taps_q[0] <= in;
          for (int t = 1; t < DEPTH; t++) taps_q[t] <= taps_q[t-1];
        end
      end

      assign out = taps_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_skew_stage.sv
// Staircase skew/deskew stage with valid/ready flow control, tile framing,
// zero-injection drain and per-tile lane masking.
//   state     | meaning
//   ST_STREAM | upstream beats flow through the delay lines
//   ST_DRAIN  | zeros injected until the deepest lane has emptied
module systolic_skew_stage
  import systolic_pkg::*;
#(
  parameter int N_LANES    = SYS_LANES,
  parameter int DATA_WIDTH = SYS_DATA_W,
  parameter bit REVERSE    = 1'b0,
  parameter int LANE_CNT_W = clog2(N_LANES + 1)
) (
  input  logic                          CLOCK,
  input  logic                          reset,
  input  logic [N_LANES*DATA_WIDTH-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [LANE_CNT_W-1:0]         active_lanes,
  output logic [N_LANES*DATA_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy
);

  localparam logic [LANE_CNT_W-1:0] LANES_C    = LANE_CNT_W'(N_LANES);
  localparam logic [LANE_CNT_W-1:0] LAST_CNT_C = LANE_CNT_W'((N_LANES > 1) ? N_LANES - 2 : 0);

  state_e                  state_q;
  logic [LANE_CNT_W-1:0]   drain_cnt_q;
  logic [LANE_CNT_W-1:0]   mask_q;
  logic                    in_tile_q;

  logic                    draining;
  logic                    advance;
  logic                    in_acc;
  logic                    drain_done;
  logic                    tile_end;
  logic [LANE_CNT_W-1:0]   mask_clamped;
  logic [LANE_CNT_W-1:0]   mask_eff;

  always_comb begin
    mask_clamped = (active_lanes > LANES_C) ? LANES_C : active_lanes;
    mask_eff     = in_tile_q ? mask_q : mask_clamped;
    draining     = (state_q == ST_DRAIN);
    // Reset gates acceptance so a beat presented during reset is never taken.
    in_ready     = !draining && out_ready && !reset;
    out_valid    = draining || in_valid;
    in_acc       = in_valid && in_ready;
    advance      = draining ? out_ready : (in_valid && out_ready);
    drain_done   = draining && (drain_cnt_q == LAST_CNT_C);
    out_last     = draining ? drain_done : ((N_LANES == 1) && in_last);
    tile_end     = advance && out_last;
    busy         = in_tile_q;
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q     <= ST_STREAM;
      drain_cnt_q <= '0;
      mask_q      <= LANES_C;
      in_tile_q   <= 1'b0;
    end else begin
      if (in_acc && !in_tile_q) mask_q <= mask_clamped;

      if (tile_end)    in_tile_q <= 1'b0;
      else if (in_acc) in_tile_q <= 1'b1;

      case (state_q)
        ST_STREAM: begin
          if (in_acc && in_last && (N_LANES > 1)) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (drain_done) state_q <= ST_STREAM;
            else            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_STREAM;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_in;
      logic [DATA_WIDTH-1:0] lane_out;

      // Masking happens ahead of the taps; drain feeds zeros.
      assign lane_in = (!draining && (LANE_CNT_W'(gi) < mask_eff))
                       ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

      lane_delay_line #(
        .DEPTH      (lane_delay(gi, N_LANES, REVERSE)),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_delay (
        .CLOCK (CLOCK),
        .reset (reset),
        .en    (advance),
        .in    (lane_in),
        .out   (lane_out)
      );

      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_out;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_skew_stage.sv
// Drives a skew and a deskew instance with identical stimulus and checks both
// against a per-tile arithmetic model of the staircase delays.
module tb_systolic_skew_stage;

  localparam int NL = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_valid, in_last, out_ready;
  logic [2:0]    active_lanes;

  logic          in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [31:0]   out_data_s;
  logic          in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [31:0]   out_data_d;

  int n_cmp = 0;
  int n_mis = 0;
  int total_out;

  logic [31:0] tile_data [16];
  int          tile_act  [16];
  logic [31:0] exp_s     [32];
  logic [31:0] exp_d     [32];
  logic [31:0] desk_log  [32];

  always #5 clk = ~clk;

  systolic_skew_stage #(.N_LANES(NL), .DATA_WIDTH(DW), .REVERSE(1'b0)) u_skew (
    .CLOCK(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_last(in_last), .active_lanes(active_lanes),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_last(out_last_s), .busy(busy_s));

  systolic_skew_stage #(.N_LANES(NL), .DATA_WIDTH(DW), .REVERSE(1'b1)) u_deskew (
    .CLOCK(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_d), .in_last(in_last), .active_lanes(active_lanes),
    .out_data(out_data_d), .out_valid(out_valid_d), .out_ready(out_ready),
    .out_last(out_last_d), .busy(busy_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output beat j, lane i carries input beat j - delay(i) when that beat exists.
  task automatic build_model(input int L);
    int act, ks, kd;
    act = (tile_act[0] > NL) ? NL : tile_act[0];
    for (int j = 0; j < L + NL - 1; j++) begin
      exp_s[j] = '0;
      exp_d[j] = '0;
      for (int i = 0; i < NL; i++) begin
        ks = j - i;
        kd = j - (NL - 1 - i);
        if (i < act) begin
          if (ks >= 0 && ks < L) exp_s[j][i*DW +: DW] = tile_data[ks][i*DW +: DW];
          if (kd >= 0 && kd < L) exp_d[j][i*DW +: DW] = tile_data[kd][i*DW +: DW];
        end
      end
    end
  endtask

  // bp_mode: 0 = always ready, 1 = random gaps both sides, 2 = 3-cycle stall at beat 1.
  // Called just after a rising edge; returns just after a rising edge unless aborted.
  task automatic run_tile(input int L, input int bp_mode, input int abort_at);
    int in_ptr, out_ptr, cyc, stall;
    logic iv, orr, drain, exp_rdy, exp_ov;
    build_model(L);
    in_ptr = 0; out_ptr = 0; cyc = 0; stall = 0;
    while (out_ptr < L + NL - 1 && cyc < 300) begin
      iv  = (in_ptr < L) && (bp_mode != 1 || $urandom_range(0, 3) != 0);
      orr = 1'b1;
      if (bp_mode == 1) orr = ($urandom_range(0, 3) != 0);
      if (bp_mode == 2 && out_ptr == 1 && stall < 3) begin
        orr = 1'b0;
        stall++;
      end
      in_valid     = iv;
      in_data      = iv ? tile_data[in_ptr] : $urandom;
      in_last      = iv && (in_ptr == L - 1);
      active_lanes = (in_ptr < L) ? 3'(tile_act[in_ptr]) : 3'($urandom_range(0, 7));
      out_ready    = orr;
      @(negedge clk);
      drain   = (in_ptr == L);
      exp_rdy = !drain && orr;
      exp_ov  = drain || iv;
      chk("in_ready_skew", {31'd0, in_ready_s}, {31'd0, exp_rdy});
      chk("in_ready_desk", {31'd0, in_ready_d}, {31'd0, exp_rdy});
      chk("out_valid_skew", {31'd0, out_valid_s}, {31'd0, exp_ov});
      chk("out_valid_desk", {31'd0, out_valid_d}, {31'd0, exp_ov});
      chk("busy", {30'd0, busy_s, busy_d}, {30'd0, in_ptr > 0, in_ptr > 0});
      if (exp_ov) begin
        chk("data_skew", out_data_s, exp_s[out_ptr]);
        chk("data_desk", out_data_d, exp_d[out_ptr]);
        chk("last", {30'd0, out_last_s, out_last_d},
            {30'd0, out_ptr == L + NL - 2, out_ptr == L + NL - 2});
        desk_log[out_ptr] = out_data_d;
      end
      if (bp_mode == 2 && !orr) chk("bp_hold", out_data_s, 32'h0000_0211);
      if (iv && exp_rdy) in_ptr++;
      if (exp_ov && orr) begin
        out_ptr++;
        total_out++;
      end
      cyc++;
      if (abort_at >= 0 && out_ptr == abort_at) break;
      @(posedge clk); #1;
    end
    if (abort_at < 0) chk("tile_done", out_ptr, L + NL - 1);
  endtask

  initial begin
    int L;
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 32'hDEAD_BEEF;
    active_lanes = 3'd4; out_ready = 1'b1; total_out = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
    chk("rst_busy", {30'd0, busy_s, busy_d}, 32'd0);
    chk("rst_last", {30'd0, out_last_s, out_last_d}, 32'd0);
    @(posedge clk); #1;

    // Directed skew tile
    tile_data[0] = 32'h0403_0201; tile_data[1] = 32'h1413_1211;
    tile_act[0] = 4; tile_act[1] = 4;
    run_tile(2, 0, -1);

    // Deskew of the skewed stream restores the original beats
    tile_data[0] = 32'h0000_0001; tile_data[1] = 32'h0000_0211;
    tile_data[2] = 32'h0003_1200; tile_data[3] = 32'h0413_0000;
    tile_data[4] = 32'h1400_0000;
    for (int k = 0; k < 5; k++) tile_act[k] = 4;
    run_tile(5, 0, -1);
    chk("desk_beat3", desk_log[3], 32'h0403_0201);
    chk("desk_beat4", desk_log[4], 32'h1413_1211);

    // Backpressure stall after output beat 1
    tile_data[0] = 32'h0403_0201; tile_data[1] = 32'h1413_1211;
    tile_act[0] = 4; tile_act[1] = 4;
    run_tile(2, 2, -1);

    // Mask latched on first beat, later change ignored
    tile_act[0] = 2; tile_act[1] = 4;
    run_tile(2, 0, -1);

    // Reset in the middle of the drain
    tile_act[0] = 4;
    run_tile(2, 0, 3);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h5555_5555; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {30'd0, out_valid_s, out_valid_d}, 32'd0);
    chk("mid_rst_busy", {30'd0, busy_s, busy_d}, 32'd0);
    chk("mid_rst_ready", {30'd0, in_ready_s, in_ready_d}, {30'd0, out_ready, out_ready});
    chk("mid_rst_last", {30'd0, out_last_s, out_last_d}, 32'd0);
    @(posedge clk); #1;
    tile_data[0] = 32'hDDCC_BBAA; tile_act[0] = 4;
    run_tile(1, 0, -1);

    // Back-to-back single-beat tiles
    total_out = 0;
    tile_data[0] = 32'h1234_5678; tile_act[0] = 4;
    run_tile(1, 0, -1);
    tile_data[0] = 32'h9ABC_DEF0; tile_act[0] = 7;
    run_tile(1, 0, -1);
    chk("b2b_beats", total_out, 8);

    // Randomized tiles with random flow control and masks
    for (int t = 0; t < 25; t++) begin
      L = $urandom_range(1, 8);
      for (int k = 0; k < L; k++) begin
        tile_data[k] = $urandom;
        tile_act[k]  = $urandom_range(0, 7);
      end
      run_tile(L, 1, -1);
    end

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/systolic_skew_stage.md
Name: systolic_skew_stage

Overview:
- Parametrised staircase skew/deskew stage for the systolic array datapath: lane i is delayed by i beats (skew) or by N_LANES-1-i beats (deskew).
- Generalises the fixed 16/32-lane input delay triangles. Adds:
  - full valid/ready flow control on both sides;
  - tile framing with in_last/out_last;
  - automatic zero-injection drain;
  - per-tile active-lane masking.
- Sits between the row/column stream adapters and the PE array (skew), or between the array and the result stream (deskew).

Parameters:
- N_LANES, 32: number of lanes; must be >= 1.
- DATA_WIDTH, 8: bits per lane.
- REVERSE, 0: 0 = lane i delay is i (skew); 1 = lane i delay is N_LANES-1-i (deskew).
- LANE_CNT_W, clog2(N_LANES+1): width of active_lanes.

Ports:
- CLOCK  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  N_LANES*DATA_WIDTH  lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage accepts a beat this cycle.
- in_last  in  1  marks the final beat of a tile (qualified by in_valid).
- active_lanes  in  LANE_CNT_W  lanes >= this value are forced to zero; sampled on the first beat of each tile.
- out_data  out  N_LANES*DATA_WIDTH  skewed/deskewed beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  final drained beat of the tile.
- busy  out  1  high from the first accepted beat of a tile until out_last is accepted.

Behaviour:
- States: STREAM, DRAIN. Reset sets STREAM, clears all delay taps to 0, clears the drain counter, clears the first-beat flag, and latches active mask = N_LANES.
- STREAM:
  - in_ready = out_ready; out_valid = in_valid.
  - advance = in_valid && out_ready.
  - out_last = in_last only when N_LANES == 1; otherwise 0.
- DRAIN:
  - in_ready = 0; out_valid = 1.
  - Zero beat is injected at the input; advance = out_ready.
  - Drain counter counts N_LANES-1 advances. out_last = 1 on the final one, and the state then returns to STREAM.
- Transition: an accepted in_last beat with N_LANES > 1 moves STREAM -> DRAIN with counter = 0.
- Delay lines:
  - Lane with delay d is a d-deep register chain; delay 0 is combinational flow-through.
  - All taps shift only on advance; otherwise everything holds (full backpressure, no data loss).
  - A tile of L beats produces exactly L+N_LANES-1 output beats; lane i input beat k appears at output beat k+delay(i).
- out_data is valid only while out_valid is high, and holds stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready; this is a deliberate flow-through path with zero latency on the delay-0 lane.
- Masking:
  - active_lanes is latched on the first accepted beat of a tile and applied to that beat and all later input beats of the tile.
  - Values > N_LANES clamp to N_LANES; 0 zeroes every lane.
  - The mask is applied before the delay taps.
- busy:
  - Set on the first accepted beat.
  - Cleared when the out_last beat is accepted, or when a STREAM beat with in_last is accepted and N_LANES == 1.
- Simultaneous in_valid and reset: reset wins; the beat is not accepted.
- Reset mid-DRAIN: residual taps are discarded and no out_last is emitted.
- Back-to-back tiles: the next tile is accepted only after returning to STREAM, i.e. the cycle after the final drain beat is accepted.

Decomposition:
- Shared package systolic_pkg holds:
  - lane_delay(i, n, reverse) function;
  - clog2 function;
  - state encodings ST_STREAM/ST_DRAIN;
  - defaults SYS_LANES=32, SYS_DATA_W=8.
- One sub-module, lane_delay_line:
  - parameters DEPTH (0 allowed = wire) and DATA_WIDTH;
  - ports CLOCK, reset (sync), en, in, out.
  - Instantiated per lane in a generate loop.

Test Plan (N_LANES=4, DATA_WIDTH=8, lanes listed 0..3):
- Skew: beats {01,02,03,04}, then {11,12,13,14} with in_last; out_ready=1. Required 5 beats:
  - {01,00,00,00}
  - {11,02,00,00}
  - {00,12,03,00}
  - {00,00,13,04}
  - {00,00,00,14}, with out_last=1 on this beat only; in_ready=0 during the last 3 beats.
- Deskew (REVERSE=1): the skew output above fed as a 5-beat tile. Required: output beats 3 and 4 are {01,02,03,04} and {11,12,13,14}; total 8 beats.
- Backpressure: as the skew scenario, with out_ready low for 3 cycles after output beat 1. Required: out_data stays {11,02,00,00}, taps frozen, sequence otherwise identical.
- Mask: active_lanes=2 on the first beat, then changed to 4 mid-tile, same data as the skew scenario. Required: lanes 2,3 are 00 in every output beat.
- Reset mid-DRAIN: assert reset after output beat 2. Required next cycle: out_valid=0, busy=0, in_ready=out_ready, no out_last. A new 1-beat tile {AA,BB,CC,DD} then yields {AA,00,00,00}, {00,BB,00,00}, {00,00,CC,00}, {00,00,00,DD}+last.
- Back-to-back: two 1-beat tiles presented continuously. Required: the second is accepted exactly the cycle after the first tile's out_last is accepted; 8 output beats total.
